tri_arbiter: RTL and testbench

Round-robin scheduler that shares one TRIANGLE classification engine among `N_REQ` requesters. Each requester hands over a three-side job in one handshake. The block serializes the three lengths into the engine, collects the engine's three-cycle result burst, and returns one packed response tagged with the requester index. It sits between the requester fabric and the single engine instance; only one job is in flight at a time.

---
 rtl/tri_arb_pkg.sv | 22 ++
 rtl/tri_arb_rr_arbiter.sv | 37 +++
 rtl/tri_arbiter.sv | 174 +++++++++++++++++
 tb/tb_tri_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tri_arb_pkg.sv
// Shared types and widths for the tri_arbiter slice: FSM state encoding and
// the side/cosine/class widths of the triangle engine interface.
package tri_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        RECV,
        RESP
    } state_t;

    localparam int LEN_W     = 8;
    localparam int COS_W     = 16;
    localparam int TRI_W     = 2;
    localparam int NUM_SIDES = 3;

    localparam int JOB_W = NUM_SIDES * LEN_W;
    localparam int RSP_W = NUM_SIDES * COS_W;

    localparam logic [1:0] LAST_BEAT = 2'(NUM_SIDES - 1);

endpackage

// File: rtl/tri_arb_rr_arbiter.sv
// Combinational round-robin picker: searches the request vector starting one
// past the last winner and returns a one-hot grant plus its encoded index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    int            w_cand;
    logic [IW-1:0] w_candIdx;
    logic          w_found;

    always_comb begin
        o_grant   = '0;
        o_idx     = '0;
        w_found   = 1'b0;
        w_cand    = 0;
        w_candIdx = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand    = (int'(i_last) + k) % N;
            w_candIdx = IW'(w_cand);
            if (!w_found && i_req[w_candIdx]) begin
                w_found            = 1'b1;
                o_grant[w_candIdx] = 1'b1;
                o_idx              = w_candIdx;
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/tri_arbiter.sv
// Round-robin front end sharing one triangle engine among N_REQ requesters.
// Optional RECV watchdog enabled by defining TRI_ARB_TIMEOUT_EN.
module tri_arbiter
    import tri_arb_pkg::*;
#(
    parameter int N_REQ = 4
`ifdef TRI_ARB_TIMEOUT_EN
    , parameter int TIMEOUT = 255
`endif
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [N_REQ-1:0]         i_req_valid,
    input  logic [N_REQ*JOB_W-1:0]   i_req_len,
    output logic [N_REQ-1:0]         o_req_ready,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [$clog2(N_REQ)-1:0] o_rsp_id,
    output logic [TRI_W-1:0]         o_rsp_tri,
    output logic [RSP_W-1:0]         o_rsp_cos,
    output logic                     o_rsp_err,
    output logic                     o_eng_in_valid,
    output logic [LEN_W-1:0]         o_eng_in_length,
    input  logic                     i_eng_out_valid,
    input  logic [COS_W-1:0]         i_eng_out_cos,
    input  logic [TRI_W-1:0]         i_eng_out_tri,
    output logic                     o_busy
);

    localparam int IW = $clog2(N_REQ);

    state_t                r_state;
    logic [1:0]            r_cnt;
    logic [IW-1:0]         r_last;
    logic [IW-1:0]         r_id;
    logic [JOB_W-LEN_W-1:0] r_pend;
    logic                  r_engInValid;
    logic [LEN_W-1:0]      r_engInLen;
    logic                  r_rspValid;
    logic [TRI_W-1:0]      r_tri;
    logic [RSP_W-1:0]      r_cos;

    logic [N_REQ-1:0]      w_grant;
    logic [IW-1:0]         w_idx;
    logic                  w_any;
    logic [JOB_W-1:0]      w_jobLen;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr (
        .i_req   (i_req_valid),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    always_comb begin
        w_jobLen = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) w_jobLen = i_req_len[i*JOB_W +: JOB_W];
        end
    end

`ifdef TRI_ARB_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [WD_W-1:0] r_wdog;
    logic            r_err;
`endif

    // Single FSM: b and c wait in r_pend and shift out one side per SEND beat.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_last       <= IW'(N_REQ - 1);
            r_id         <= '0;
            r_pend       <= '0;
            r_engInValid <= 1'b0;
            r_engInLen   <= '0;
            r_rspValid   <= 1'b0;
            r_tri        <= '0;
            r_cos        <= '0;
`ifdef TRI_ARB_TIMEOUT_EN
            r_wdog       <= '0;
            r_err        <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_last       <= w_idx;
                        r_id         <= w_idx;
                        r_engInValid <= 1'b1;
                        r_engInLen   <= w_jobLen[LEN_W-1:0];
                        r_pend       <= w_jobLen[JOB_W-1:LEN_W];
                        r_cnt        <= '0;
`ifdef TRI_ARB_TIMEOUT_EN
                        r_err        <= 1'b0;
`endif
                        r_state      <= SEND;
                    end
                end
                SEND: begin
                    if (r_cnt == LAST_BEAT) begin
                        r_engInValid <= 1'b0;
                        r_engInLen   <= '0;
                        r_cnt        <= '0;
`ifdef TRI_ARB_TIMEOUT_EN
                        r_wdog       <= '0;
`endif
                        r_state      <= RECV;
                    end else begin
                        r_cnt      <= r_cnt + 2'd1;
                        r_engInLen <= r_pend[LEN_W-1:0];
                        r_pend     <= r_pend >> LEN_W;
                    end
                end
                RECV: begin
                    if (i_eng_out_valid) begin
                        r_cos[r_cnt*COS_W +: COS_W] <= i_eng_out_cos;
                        if (r_cnt == 2'd0) r_tri <= i_eng_out_tri;
`ifdef TRI_ARB_TIMEOUT_EN
                        r_wdog <= '0;
`endif
                        if (r_cnt == LAST_BEAT) begin
                            r_cnt      <= '0;
                            r_rspValid <= 1'b1;
                            r_state    <= RESP;
                        end else begin
                            r_cnt <= r_cnt + 2'd1;
                        end
                    end
`ifdef TRI_ARB_TIMEOUT_EN
                    // A silent engine yields an error response with zeroed payload.
                    else if (r_wdog == WD_W'(TIMEOUT - 1)) begin
                        r_cnt      <= '0;
                        r_tri      <= '0;
                        r_cos      <= '0;
                        r_err      <= 1'b1;
                        r_rspValid <= 1'b1;
                        r_state    <= RESP;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        r_rspValid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_req_ready     = (r_state == IDLE) ? w_grant : '0;
    assign o_rsp_valid     = r_rspValid;
    assign o_rsp_id        = r_id;
    assign o_rsp_tri       = r_tri;
    assign o_rsp_cos       = r_cos;
    assign o_eng_in_valid  = r_engInValid;
    assign o_eng_in_length = r_engInLen;
    assign o_busy          = (r_state != IDLE);
`ifdef TRI_ARB_TIMEOUT_EN
    assign o_rsp_err       = r_err;
`else
    assign o_rsp_err       = 1'b0;
`endif

endmodule

// File: tb/tb_tri_arbiter.sv
// Self-checking bench for tri_arbiter: table of jobs plus hand-written
// sequences for held requests, mid-job reset and the RECV watchdog.
module tb_tri_arbiter;

    localparam int N = 4;

    typedef struct {
        int          id;
        logic [1:0]  triVal;
        logic [47:0] cosVal;
        logic        err;
    } rsp_t;

    typedef struct {
        logic [3:0]  valid;
        logic [7:0]  base;
        logic [1:0]  triVal;
        logic [47:0] cosVal;
        int          g0;
        int          g1;
        int          g2;
        bit          stray;
        int          hold;
        int          expId;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  reqValid;
    logic [95:0] reqLen;
    logic [3:0]  reqReady;
    logic        rspValid;
    logic        rspReady;
    logic [1:0]  rspId;
    logic [1:0]  rspTri;
    logic [47:0] rspCos;
    logic        rspErr;
    logic        engInValid;
    logic [7:0]  engInLength;
    logic        engOutValid;
    logic [15:0] engOutCos;
    logic [1:0]  engOutTri;
    logic        busy;

    int   checks = 0;
    int   errors = 0;
    rsp_t sb[$];
    vec_t vecs[7];

    always #5 clk = ~clk;

    tri_arbiter #(
        .N_REQ (N)
`ifdef TRI_ARB_TIMEOUT_EN
        , .TIMEOUT (16)
`endif
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_req_valid     (reqValid),
        .i_req_len       (reqLen),
        .o_req_ready     (reqReady),
        .o_rsp_valid     (rspValid),
        .i_rsp_ready     (rspReady),
        .o_rsp_id        (rspId),
        .o_rsp_tri       (rspTri),
        .o_rsp_cos       (rspCos),
        .o_rsp_err       (rspErr),
        .o_eng_in_valid  (engInValid),
        .o_eng_in_length (engInLength),
        .i_eng_out_valid (engOutValid),
        .i_eng_out_cos   (engOutCos),
        .i_eng_out_tri   (engOutTri),
        .o_busy          (busy)
    );

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Requester i gets sides a = base + 16*i, b = a+1, c = a+2.
    function automatic logic [95:0] makeLen(input logic [7:0] base);
        logic [95:0] v;
        logic [7:0]  a;
        v = '0;
        for (int i = 0; i < N; i++) begin
            a = base + 8'(i * 16);
            v[i*24 +: 24] = {a + 8'd2, a + 8'd1, a};
        end
        return v;
    endfunction

    // Called on a negedge in IDLE; returns on the negedge of RECV cycle 0.
    task automatic startJob(input logic [3:0] valid, input logic [7:0] base, input int expId,
                            input bit stray, input bit keepValid);
        logic [7:0] a;
        logic [3:0] expGrant;
        a        = base + 8'(expId * 16);
        expGrant = 4'b0001 << expId;
        reqValid = valid;
        reqLen   = makeLen(base);
        #1;
        checkVal("grant", {60'd0, reqReady}, {60'd0, expGrant});
        @(negedge clk);
        if (!keepValid) reqValid = 4'b0000;
        if (stray) begin
            engOutValid = 1'b1;
            engOutCos   = 16'hDEAD;
            engOutTri   = 2'b11;
        end
        for (int k = 0; k < 3; k++) begin
            checkVal("engInValid", {63'd0, engInValid}, 64'd1);
            checkVal("engInLength", {56'd0, engInLength}, {56'd0, a + 8'(k)});
            checkVal("reqReadyBusy", {60'd0, reqReady}, 64'd0);
            @(negedge clk);
        end
        engOutValid = 1'b0;
        engOutCos   = '0;
        engOutTri   = '0;
        checkVal("engInDone", {63'd0, engInValid}, 64'd0);
    endtask

    task automatic checkOutput();
        rsp_t e;
        checkVal("rspValid", {63'd0, rspValid}, 64'd1);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: got response, expected none");
        end else begin
            e = sb.pop_front();
            checkVal("rspId", {62'd0, rspId}, 64'(e.id));
            checkVal("rspTri", {62'd0, rspTri}, {62'd0, e.triVal});
            checkVal("rspCos", {16'd0, rspCos}, {16'd0, e.cosVal});
            checkVal("rspErr", {63'd0, rspErr}, {63'd0, e.err});
        end
        rspReady = 1'b1;
        @(negedge clk);
        rspReady = 1'b0;
        checkVal("rspDrop", {63'd0, rspValid}, 64'd0);
        checkVal("busyIdle", {63'd0, busy}, 64'd0);
    endtask

    task automatic applyStimulus(input vec_t v, input bit keepValid);
        int gaps[3];
        gaps = '{v.g0, v.g1, v.g2};
        sb.push_back('{id: v.expId, triVal: v.triVal, cosVal: v.cosVal, err: 1'b0});
        startJob(v.valid, v.base, v.expId, v.stray, keepValid);
        for (int k = 0; k < 3; k++) begin
            repeat (gaps[k]) @(negedge clk);
            engOutValid = 1'b1;
            engOutCos   = v.cosVal[k*16 +: 16];
            engOutTri   = (k == 0) ? v.triVal : ~v.triVal;
            @(negedge clk);
            engOutValid = 1'b0;
        end
        checkVal("rspLatency", {63'd0, rspValid}, 64'd1);
        if (v.hold > 0) begin
            reqValid = 4'b1111;
            repeat (v.hold) begin
                @(negedge clk);
                checkVal("holdValid", {63'd0, rspValid}, 64'd1);
                checkVal("holdCos", {16'd0, rspCos}, {16'd0, v.cosVal});
                checkVal("holdId", {62'd0, rspId}, 64'(v.expId));
                checkVal("holdReady", {60'd0, reqReady}, 64'd0);
                checkVal("holdEng", {63'd0, engInValid}, 64'd0);
            end
            reqValid = keepValid ? v.valid : 4'b0000;
        end
        checkOutput();
    endtask

    initial begin
        int   lowCount;
        int   rspSeen;
        vec_t hv;

        vecs[0] = '{4'b0001, 8'h03, 2'd2, 48'h4CCC_6666_0000, 0, 0, 0, 1'b0, 0,  0};
        vecs[1] = '{4'b0101, 8'h20, 2'd1, 48'h1111_2222_3333, 0, 0, 0, 1'b0, 10, 2};
        vecs[2] = '{4'b0101, 8'h40, 2'd3, 48'hA5A5_5A5A_0F0F, 0, 0, 0, 1'b0, 0,  0};
        vecs[3] = '{4'b1000, 8'h10, 2'd0, 48'h0001_8000_FFFF, 0, 2, 0, 1'b0, 0,  3};
        vecs[4] = '{4'b1000, 8'h77, 2'd2, 48'hBEEF_CAFE_1234, 0, 0, 0, 1'b0, 0,  3};
        vecs[5] = '{4'b0110, 8'h05, 2'd1, 48'h0F00_00F0_000F, 0, 0, 0, 1'b1, 0,  1};
        vecs[6] = '{4'b1011, 8'hC0, 2'd3, 48'h7FFF_8001_2468, 1, 1, 1, 1'b0, 0,  3};

        rst = 1'b1; reqValid = '0; reqLen = '0; rspReady = 1'b0;
        engOutValid = 1'b0; engOutCos = '0; engOutTri = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkVal("rstReqReady", {60'd0, reqReady}, 64'd0);
        checkVal("rstRspValid", {63'd0, rspValid}, 64'd0);
        checkVal("rstRspPayload", {rspErr, rspTri, rspId, rspCos}, 64'd0);
        checkVal("rstEng", {55'd0, engInValid, engInLength}, 64'd0);
        checkVal("rstBusy", {63'd0, busy}, 64'd0);

        rspReady = 1'b1;
        repeat (2) @(negedge clk);
        rspReady = 1'b0;
        checkVal("idleRspReady", {62'd0, busy, rspValid}, 64'd0);

        for (int i = 0; i < 7; i++) applyStimulus(vecs[i], 1'b0);

        // All four requesters held valid: strict rotation 0,1,2,3,0.
        for (int j = 0; j < 5; j++) begin
            hv = '{4'b1111, 8'(8'h30 + j), 2'(j), {16'(j * 3 + 1), 16'(j * 3 + 2), 16'(j * 3 + 3)},
                   0, 0, 0, 1'b0, 0, j % 4};
            applyStimulus(hv, 1'b1);
        end
        reqValid = 4'b0000;

        // Reset mid-RECV after one beat: job vanishes, pointer returns to N-1.
        startJob(4'b0010, 8'h50, 1, 1'b0, 1'b0);
        engOutValid = 1'b1;
        engOutCos   = 16'h1234;
        @(negedge clk);
        engOutValid = 1'b0;
        rst = 1'b1;
        reqValid = 4'b0101;
        @(negedge clk);
        rst = 1'b0;
        checkVal("rstMidBusy", {63'd0, busy}, 64'd0);
        checkVal("rstMidRsp", {63'd0, rspValid}, 64'd0);
        hv = '{4'b0101, 8'h60, 2'd1, 48'h0102_0304_0506, 0, 0, 0, 1'b0, 0, 0};
        applyStimulus(hv, 1'b0);

        startJob(4'b0001, 8'h90, 0, 1'b0, 1'b0);
`ifdef TRI_ARB_TIMEOUT_EN
        sb.push_back('{id: 0, triVal: 2'd0, cosVal: 48'd0, err: 1'b1});
        rspSeen = 0;
        repeat (15) begin
            @(negedge clk);
            if (rspValid) rspSeen++;
        end
        @(negedge clk);
        checkVal("timeoutEarly", 64'(rspSeen), 64'd0);
        checkOutput();
`else
        lowCount = 0;
        rspSeen  = 0;
        repeat (110) begin
            @(negedge clk);
            if (!busy) lowCount++;
            if (rspValid) rspSeen++;
        end
        checkVal("busyStuck", 64'(lowCount), 64'd0);
        checkVal("noRspSilent", 64'(rspSeen), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkVal("busyAfterRst", {63'd0, busy}, 64'd0);
`endif

        checkVal("sbEmpty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
